cl_capture_ctrl: RTL and testbench

CL_CAPTURE_CTRL -- requirements
Module: cl_capture_ctrl

---
 rtl/cl_capture_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cl_capture_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_capture_ctrl.sv
// cl_capture_ctrl -- Camera Link frame capture controller.
//
// Takes ARM / STOP / CLEAR commands from the PC side and watches the camera's
// frame/line valid strobes. It gates the pixel datapath (capture_en) for a
// programmed number of frames, or continuously. It counts completed frames,
// lines and pixel clocks, and posts 128-bit status messages downstream.
//
// Optional feature macro: CL_FRAME_DONE_MSG_EN
//   defined   -> a FRAME_DONE message is posted after every captured frame
//   undefined -> only ERROR messages are ever posted
//
// Ports:
//   bus_clk            sole clock
//   reset              asynchronous, active-high
//   pc_msg_pending     PC command available
//   pc_msg[31:0]       command word: [31:28] opcode, [19:0] argument
//   pc_msg_ack         one-cycle command-consumed pulse
//   cl_fval, cl_lval   frame/line valid, already synchronous to bus_clk
//   fpga_msg_overflow  downstream message FIFO full
//   fpga_msg[127:0]    status message, held until the next one
//   fpga_msg_valid     one-cycle message strobe
//   capture_en         high exactly while CAPTURING
//   state[1:0]         STANDBY=0, ARMED=1, CAPTURING=2, ERROR=3
//   frame_num          completed-frame count
//   led[3:0]           {error, capturing, armed, frame_num[0]}
module cl_capture_ctrl #(
  parameter int FRAME_NUM_SIZE = 20,
  parameter int LINE_NUM_SIZE  = 12,
  parameter int CLK_COUNT_SIZE = 10
) (
  input  logic                      bus_clk,
  input  logic                      reset,
  input  logic                      pc_msg_pending,
  input  logic [31:0]               pc_msg,
  output logic                      pc_msg_ack,
  input  logic                      cl_fval,
  input  logic                      cl_lval,
  input  logic                      fpga_msg_overflow,
  output logic [127:0]              fpga_msg,
  output logic                      fpga_msg_valid,
  output logic                      capture_en,
  output logic [1:0]                state,
  output logic [FRAME_NUM_SIZE-1:0] frame_num,
  output logic [3:0]                led
);

  typedef enum logic [1:0] {
    STANDBY   = 2'd0,
    ARMED     = 2'd1,
    CAPTURING = 2'd2,
    ERROR     = 2'd3
  } state_e;

  localparam logic [3:0] OP_ARM   = 4'd1;
  localparam logic [3:0] OP_STOP  = 4'd2;
  localparam logic [3:0] OP_CLEAR = 4'd3;

  localparam logic [3:0] MSG_FRAME_DONE = 4'd2;
  localparam logic [3:0] MSG_ERROR      = 4'd3;

  localparam logic [FRAME_NUM_SIZE-1:0] FRAME_ONE = {{(FRAME_NUM_SIZE-1){1'b0}}, 1'b1};
  localparam logic [LINE_NUM_SIZE-1:0]  LINE_ONE  = {{(LINE_NUM_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CLK_COUNT_SIZE-1:0] CLK_ONE   = {{(CLK_COUNT_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CLK_COUNT_SIZE-1:0] CLK_MAX   = {CLK_COUNT_SIZE{1'b1}};

  state_e state_q, state_next;

  logic                      fval_d, lval_d;
  logic [LINE_NUM_SIZE-1:0]  line_num;
  logic [CLK_COUNT_SIZE-1:0] clk_count;
  logic [19:0]               frames_left;
  logic                      stop_pending;

  logic       fval_rise, fval_fall, lval_rise;
  logic       cmd_take, cmd_arm, cmd_stop, cmd_clear;
  logic [3:0] opcode;
  logic       continuous, last_frame;

  // Events produced by the next-state logic for the datapath registers.
  logic frame_done, err_evt, cap_start, arm_load, stop_set;

  logic unused_msg_bits;
  assign unused_msg_bits = ^pc_msg[27:20];

  assign fval_rise = cl_fval & ~fval_d;
  assign fval_fall = ~cl_fval & fval_d;
  assign lval_rise = cl_lval & ~lval_d;

  // A command is taken only while the previous ack is low.
  // The one-cycle ack pulse then masks the still-pending request.
  assign cmd_take  = pc_msg_pending & ~pc_msg_ack;
  assign opcode    = pc_msg[31:28];
  assign cmd_arm   = cmd_take & (opcode == OP_ARM);
  assign cmd_stop  = cmd_take & (opcode == OP_STOP);
  assign cmd_clear = cmd_take & (opcode == OP_CLEAR);

  // A frames_left of zero while capturing means the ARM was continuous.
  assign continuous = (frames_left == 20'd0);
  assign last_frame = (frames_left == 20'd1);

  // State register.
  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) state_q <= STANDBY;
    else       state_q <= state_next;
  end

  // Next-state logic. The fval edge is resolved first into mid_state.
  // The command is then judged against that result, so a command arriving
  // together with a frame edge sees the post-edge state.
  always_comb begin
    state_e mid_state;
    mid_state  = state_q;
    state_next = state_q;
    frame_done = 1'b0;
    err_evt    = 1'b0;
    cap_start  = 1'b0;
    arm_load   = 1'b0;
    stop_set   = 1'b0;

    case (state_q)
      ARMED: begin
        if (fval_rise) begin
          mid_state = CAPTURING;
          cap_start = 1'b1;
        end
      end
      CAPTURING: begin
        // Overflow beats a coincident frame end; that frame is not counted.
        if (fpga_msg_overflow) begin
          mid_state = ERROR;
          err_evt   = 1'b1;
        end else if (fval_fall) begin
          frame_done = 1'b1;
          mid_state  = (stop_pending || (!continuous && last_frame)) ? STANDBY : ARMED;
        end
      end
      default: ;
    endcase

    state_next = mid_state;
    if (cmd_clear) begin
      state_next = STANDBY;
    end else if (cmd_arm) begin
      if (mid_state == STANDBY) begin
        state_next = ARMED;
        arm_load   = 1'b1;
      end
    end else if (cmd_stop) begin
      if (mid_state == ARMED)          state_next = STANDBY;
      else if (mid_state == CAPTURING) stop_set   = 1'b1;
    end
  end

  // Output logic.
  always_comb begin
    capture_en = (state_q == CAPTURING);
    led        = {state_q == ERROR, state_q == CAPTURING, state_q == ARMED, frame_num[0]};
  end

  assign state = state_q;

  // Command ack and the fval/lval edge-detect history.
  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      pc_msg_ack <= 1'b0;
      fval_d     <= 1'b0;
      lval_d     <= 1'b0;
    end else begin
      pc_msg_ack <= cmd_take;
      fval_d     <= cl_fval;
      lval_d     <= cl_lval;
    end
  end

  // Frame bookkeeping: completed-frame count, frames still to take, and
  // a STOP deferred until the current frame ends.
  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      frame_num    <= '0;
      frames_left  <= '0;
      stop_pending <= 1'b0;
    end else if (cmd_clear) begin
      frame_num    <= '0;
      frames_left  <= '0;
      stop_pending <= 1'b0;
    end else begin
      if (frame_done) frame_num <= frame_num + FRAME_ONE;

      if (arm_load)                       frames_left <= pc_msg[19:0];
      else if (frame_done && !continuous) frames_left <= frames_left - 20'd1;

      if (stop_set)                     stop_pending <= 1'b1;
      else if (frame_done || err_evt)   stop_pending <= 1'b0;
    end
  end

  // Line and pixel-clock counters. The cycle of the lval rise clears
  // clk_count, and each later lval-high cycle adds one. An N-cycle line
  // therefore ends at N-1, saturating at all-ones. A line starting on the
  // same cycle as the frame counts as line 1 of that frame.
  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      line_num  <= '0;
      clk_count <= '0;
    end else if (cmd_clear) begin
      line_num  <= '0;
      clk_count <= '0;
    end else begin
      if (cap_start)
        line_num <= lval_rise ? LINE_ONE : '0;
      else if (state_q == CAPTURING && cl_fval && lval_rise)
        line_num <= line_num + LINE_ONE;

      if (lval_rise)
        clk_count <= '0;
      else if (cl_lval && clk_count != CLK_MAX)
        clk_count <= clk_count + CLK_ONE;
    end
  end

  // Message fields fitted to their fixed slot widths, zero-extended or truncated.
  logic [FRAME_NUM_SIZE-1:0] msg_frame_src;
  logic [19:0]               frame_field;
  logic [11:0]               line_field;
  logic [9:0]                clk_field;
  logic [3:0]                msg_type;
  logic [127:0]              msg_word;

  assign msg_frame_src = frame_done ? frame_num + FRAME_ONE : frame_num;

  if (FRAME_NUM_SIZE >= 20) begin : g_frame_field
    assign frame_field = msg_frame_src[19:0];
  end else begin : g_frame_field
    assign frame_field = {{(20-FRAME_NUM_SIZE){1'b0}}, msg_frame_src};
  end

  if (LINE_NUM_SIZE >= 12) begin : g_line_field
    assign line_field = line_num[11:0];
  end else begin : g_line_field
    assign line_field = {{(12-LINE_NUM_SIZE){1'b0}}, line_num};
  end

  if (CLK_COUNT_SIZE >= 10) begin : g_clk_field
    assign clk_field = clk_count[9:0];
  end else begin : g_clk_field
    assign clk_field = {{(10-CLK_COUNT_SIZE){1'b0}}, clk_count};
  end

  assign msg_type = err_evt ? MSG_ERROR : MSG_FRAME_DONE;
  assign msg_word = {8'hA5, msg_type, frame_field, line_field, clk_field, 74'd0};

  // Message register. ERROR always goes out, even into a full FIFO.
  // FRAME_DONE is dropped when the FIFO is full.
  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      fpga_msg       <= '0;
      fpga_msg_valid <= 1'b0;
    end else begin
      fpga_msg_valid <= 1'b0;
      if (err_evt) begin
        fpga_msg       <= msg_word;
        fpga_msg_valid <= 1'b1;
      end
`ifdef CL_FRAME_DONE_MSG_EN
      else if (frame_done && !fpga_msg_overflow) begin
        fpga_msg       <= msg_word;
        fpga_msg_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cl_capture_ctrl.sv
// tb_cl_capture_ctrl -- directed self-checking bench for cl_capture_ctrl.
// Each test task drives a scenario and checks results inline.
// Inputs change and outputs are read on the falling clock edge.
module tb_cl_capture_ctrl;

  logic         bus_clk = 1'b0;
  logic         reset = 1'b1;
  logic         pc_msg_pending = 1'b0;
  logic [31:0]  pc_msg = '0;
  logic         pc_msg_ack;
  logic         cl_fval = 1'b0;
  logic         cl_lval = 1'b0;
  logic         fpga_msg_overflow = 1'b0;
  logic [127:0] fpga_msg;
  logic         fpga_msg_valid;
  logic         capture_en;
  logic [1:0]   state;
  logic [19:0]  frame_num;
  logic [3:0]   led;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [127:0] msgs[$];

`ifdef CL_FRAME_DONE_MSG_EN
  localparam int FD = 1;
`else
  localparam int FD = 0;
`endif

  cl_capture_ctrl dut (
    .bus_clk(bus_clk), .reset(reset),
    .pc_msg_pending(pc_msg_pending), .pc_msg(pc_msg), .pc_msg_ack(pc_msg_ack),
    .cl_fval(cl_fval), .cl_lval(cl_lval), .fpga_msg_overflow(fpga_msg_overflow),
    .fpga_msg(fpga_msg), .fpga_msg_valid(fpga_msg_valid), .capture_en(capture_en),
    .state(state), .frame_num(frame_num), .led(led)
  );

  always #5 bus_clk = ~bus_clk;

  // Collect every posted message; valid lasts one full cycle, so one falling edge sees it.
  always @(negedge bus_clk) if (fpga_msg_valid === 1'b1) msgs.push_back(fpga_msg);

  function automatic logic [127:0] exp_msg(input logic [3:0] t, input logic [19:0] f,
                                           input logic [11:0] l, input logic [9:0] c);
    return {8'hA5, t, f, l, c, 74'd0};
  endfunction

  task automatic do_reset();
    reset = 1'b1; pc_msg_pending = 1'b0; pc_msg = '0;
    cl_fval = 1'b0; cl_lval = 1'b0; fpga_msg_overflow = 1'b0;
    repeat (3) @(negedge bus_clk);
    reset = 1'b0;
    @(negedge bus_clk);
    msgs.delete();
  endtask

  // Issue one command and wait (bounded) for its ack, which must last one cycle.
  task automatic send_cmd(input logic [3:0] op, input logic [19:0] arg);
    bit got = 0;
    pc_msg = {op, 8'h00, arg};
    pc_msg_pending = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge bus_clk);
      if (pc_msg_ack === 1'b1) begin got = 1; break; end
    end
    pc_msg_pending = 1'b0;
    n_compared++;
    if (!got) begin n_mismatched++; $display("[TB] FAIL cmd_ack_timeout op=%0d actual=0 expected=1", op); end
    @(negedge bus_clk);
    n_compared++;
    if (pc_msg_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL cmd_ack_width actual=%b expected=0", pc_msg_ack); end
  endtask

  task automatic frame_start();
    cl_fval = 1'b1; cl_lval = 1'b0;
    repeat (2) @(negedge bus_clk);
  endtask

  task automatic lines(input int n, input int len, input int gap);
    for (int i = 0; i < n; i++) begin
      cl_lval = 1'b1;
      repeat (len) @(negedge bus_clk);
      cl_lval = 1'b0;
      repeat (gap) @(negedge bus_clk);
    end
  endtask

  task automatic frame_end();
    cl_fval = 1'b0; cl_lval = 1'b0;
    repeat (2) @(negedge bus_clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL rst_state actual=%0d expected=0", state); end
    n_compared++; if (capture_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_capture_en actual=%b expected=0", capture_en); end
    n_compared++; if (frame_num !== 20'd0) begin n_mismatched++; $display("[TB] FAIL rst_frame_num actual=%0d expected=0", frame_num); end
    n_compared++; if (led !== 4'd0) begin n_mismatched++; $display("[TB] FAIL rst_led actual=%b expected=0000", led); end
    n_compared++; if (pc_msg_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_ack actual=%b expected=0", pc_msg_ack); end
    n_compared++; if (fpga_msg_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_msg_valid actual=%b expected=0", fpga_msg_valid); end
    n_compared++; if (fpga_msg !== 128'd0) begin n_mismatched++; $display("[TB] FAIL rst_msg actual=%h expected=0", fpga_msg); end
    send_cmd(4'hF, 20'd5);
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL unknown_op_state actual=%0d expected=0", state); end
  endtask

  task automatic test_arm_two_frames();
    int exp_n;
    do_reset();
    send_cmd(4'd1, 20'd2);
    n_compared++; if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL arm2_armed actual=%0d expected=1", state); end
    n_compared++; if (led !== 4'b0010) begin n_mismatched++; $display("[TB] FAIL arm2_led actual=%b expected=0010", led); end
    frame_start();
    n_compared++; if (state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL arm2_f1_state actual=%0d expected=2", state); end
    n_compared++; if (capture_en !== 1'b1) begin n_mismatched++; $display("[TB] FAIL arm2_f1_cap actual=%b expected=1", capture_en); end
    lines(4, 8, 3); frame_end();
    n_compared++; if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL arm2_f1_end_state actual=%0d expected=1", state); end
    n_compared++; if (frame_num !== 20'd1) begin n_mismatched++; $display("[TB] FAIL arm2_f1_frame_num actual=%0d expected=1", frame_num); end
    frame_start(); lines(4, 8, 3); frame_end();
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL arm2_f2_end_state actual=%0d expected=0", state); end
    frame_start();
    n_compared++; if (capture_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL arm2_f3_cap actual=%b expected=0", capture_en); end
    lines(4, 8, 3); frame_end();
    n_compared++; if (frame_num !== 20'd2) begin n_mismatched++; $display("[TB] FAIL arm2_final_frame_num actual=%0d expected=2", frame_num); end
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL arm2_final_state actual=%0d expected=0", state); end
    exp_n = 2 * FD;
    n_compared++; if (msgs.size() != exp_n) begin n_mismatched++; $display("[TB] FAIL arm2_msg_count actual=%0d expected=%0d", msgs.size(), exp_n); end
`ifdef CL_FRAME_DONE_MSG_EN
    if (msgs.size() >= 2) begin
      n_compared++; if (msgs[0] !== exp_msg(4'd2, 20'd1, 12'd4, 10'd7)) begin n_mismatched++; $display("[TB] FAIL arm2_msg0 actual=%h expected=%h", msgs[0], exp_msg(4'd2, 20'd1, 12'd4, 10'd7)); end
      n_compared++; if (msgs[1] !== exp_msg(4'd2, 20'd2, 12'd4, 10'd7)) begin n_mismatched++; $display("[TB] FAIL arm2_msg1 actual=%h expected=%h", msgs[1], exp_msg(4'd2, 20'd2, 12'd4, 10'd7)); end
    end
`endif
  endtask

  task automatic test_arm_mid_frame();
    do_reset();
    frame_start();
    send_cmd(4'd1, 20'd1);
    n_compared++; if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL midarm_state actual=%0d expected=1", state); end
    lines(2, 8, 3); frame_end();
    n_compared++; if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL midarm_skip_state actual=%0d expected=1", state); end
    n_compared++; if (frame_num !== 20'd0) begin n_mismatched++; $display("[TB] FAIL midarm_skip_frame_num actual=%0d expected=0", frame_num); end
    frame_start();
    n_compared++; if (state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL midarm_cap_state actual=%0d expected=2", state); end
    lines(3, 8, 3); frame_end();
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL midarm_end_state actual=%0d expected=0", state); end
    n_compared++; if (frame_num !== 20'd1) begin n_mismatched++; $display("[TB] FAIL midarm_frame_num actual=%0d expected=1", frame_num); end
`ifdef CL_FRAME_DONE_MSG_EN
    n_compared++; if (msgs.size() != 1) begin n_mismatched++; $display("[TB] FAIL midarm_msg_count actual=%0d expected=1", msgs.size()); end
    else begin
      n_compared++; if (msgs[0] !== exp_msg(4'd2, 20'd1, 12'd3, 10'd7)) begin n_mismatched++; $display("[TB] FAIL midarm_msg actual=%h expected=%h", msgs[0], exp_msg(4'd2, 20'd1, 12'd3, 10'd7)); end
    end
`endif
  endtask

  task automatic test_stop_mid_frame();
    do_reset();
    send_cmd(4'd1, 20'd0);
    frame_start(); lines(2, 8, 3); frame_end();
    n_compared++; if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL stop_cont_state actual=%0d expected=1", state); end
    n_compared++; if (frame_num !== 20'd1) begin n_mismatched++; $display("[TB] FAIL stop_cont_frame_num actual=%0d expected=1", frame_num); end
    frame_start(); lines(2, 8, 3);
    send_cmd(4'd2, 20'd0);
    n_compared++; if (state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL stop_still_cap actual=%0d expected=2", state); end
    n_compared++; if (capture_en !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stop_cap_en actual=%b expected=1", capture_en); end
    lines(2, 8, 3); frame_end();
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL stop_end_state actual=%0d expected=0", state); end
    n_compared++; if (frame_num !== 20'd2) begin n_mismatched++; $display("[TB] FAIL stop_frame_num actual=%0d expected=2", frame_num); end
`ifdef CL_FRAME_DONE_MSG_EN
    n_compared++; if (msgs.size() != 2) begin n_mismatched++; $display("[TB] FAIL stop_msg_count actual=%0d expected=2", msgs.size()); end
    else begin
      n_compared++; if (msgs[1] !== exp_msg(4'd2, 20'd2, 12'd4, 10'd7)) begin n_mismatched++; $display("[TB] FAIL stop_msg actual=%h expected=%h", msgs[1], exp_msg(4'd2, 20'd2, 12'd4, 10'd7)); end
    end
`endif
  endtask

  task automatic test_overflow();
    int exp_n;
    do_reset();
    send_cmd(4'd1, 20'd0);
    frame_start(); lines(2, 8, 3); frame_end();
    frame_start(); lines(2, 8, 3);
    fpga_msg_overflow = 1'b1;
    @(negedge bus_clk);
    n_compared++; if (state !== 2'd3) begin n_mismatched++; $display("[TB] FAIL ovf_state actual=%0d expected=3", state); end
    n_compared++; if (capture_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ovf_cap_en actual=%b expected=0", capture_en); end
    n_compared++; if (led !== 4'b1001) begin n_mismatched++; $display("[TB] FAIL ovf_led actual=%b expected=1001", led); end
    fpga_msg_overflow = 1'b0;
    @(negedge bus_clk);
    exp_n = FD + 1;
    n_compared++; if (msgs.size() != exp_n) begin n_mismatched++; $display("[TB] FAIL ovf_msg_count actual=%0d expected=%0d", msgs.size(), exp_n); end
    if (msgs.size() > 0) begin
      n_compared++; if (msgs[msgs.size()-1] !== exp_msg(4'd3, 20'd1, 12'd2, 10'd7)) begin n_mismatched++; $display("[TB] FAIL ovf_err_msg actual=%h expected=%h", msgs[msgs.size()-1], exp_msg(4'd3, 20'd1, 12'd2, 10'd7)); end
    end
    frame_end();
    send_cmd(4'd2, 20'd0);
    n_compared++; if (state !== 2'd3) begin n_mismatched++; $display("[TB] FAIL ovf_stop_ignored actual=%0d expected=3", state); end
    send_cmd(4'd3, 20'd0);
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL clear_state actual=%0d expected=0", state); end
    n_compared++; if (frame_num !== 20'd0) begin n_mismatched++; $display("[TB] FAIL clear_frame_num actual=%0d expected=0", frame_num); end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    send_cmd(4'd1, 20'd0);
    frame_start();
    cl_lval = 1'b1;
    repeat (1100) @(negedge bus_clk);
    cl_lval = 1'b0;
    repeat (2) @(negedge bus_clk);
    fpga_msg_overflow = 1'b1;
    @(negedge bus_clk);
    fpga_msg_overflow = 1'b0;
    @(negedge bus_clk);
    n_compared++; if (msgs.size() != 1) begin n_mismatched++; $display("[TB] FAIL sat_msg_count actual=%0d expected=1", msgs.size()); end
    if (msgs.size() > 0) begin
      n_compared++; if (msgs[0] !== exp_msg(4'd3, 20'd0, 12'd1, 10'd1023)) begin n_mismatched++; $display("[TB] FAIL sat_clk_count_msg actual=%h expected=%h", msgs[0], exp_msg(4'd3, 20'd0, 12'd1, 10'd1023)); end
    end
    frame_end();
    send_cmd(4'd3, 20'd0);
    send_cmd(4'd1, 20'd0);
    frame_start(); lines(1, 8, 3); frame_end();
    n_compared++; if (led !== 4'b0011) begin n_mismatched++; $display("[TB] FAIL pre_rst_led actual=%b expected=0011", led); end
    frame_start();
    cl_lval = 1'b1;
    repeat (3) @(negedge bus_clk);
    reset = 1'b1;
    #1;
    n_compared++; if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL midrst_state actual=%0d expected=0", state); end
    n_compared++; if (capture_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_cap_en actual=%b expected=0", capture_en); end
    n_compared++; if (frame_num !== 20'd0) begin n_mismatched++; $display("[TB] FAIL midrst_frame_num actual=%0d expected=0", frame_num); end
    n_compared++; if (led !== 4'd0) begin n_mismatched++; $display("[TB] FAIL midrst_led actual=%b expected=0000", led); end
    n_compared++; if (fpga_msg !== 128'd0) begin n_mismatched++; $display("[TB] FAIL midrst_msg actual=%h expected=0", fpga_msg); end
    n_compared++; if (fpga_msg_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_msg_valid actual=%b expected=0", fpga_msg_valid); end
    n_compared++; if (pc_msg_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_ack actual=%b expected=0", pc_msg_ack); end
    cl_fval = 1'b0; cl_lval = 1'b0;
    repeat (2) @(negedge bus_clk);
    reset = 1'b0;
    @(negedge bus_clk);
  endtask

  initial begin
    $display("[TB] start, frame-done messages %0s", FD ? "enabled" : "disabled");
    test_reset();
    test_arm_two_frames();
    test_arm_mid_frame();
    test_stop_mid_frame();
    test_overflow();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
